imm_gen_buf: RTL and testbench
==============================

Name: imm_gen_buf

Overview:
- Parametrised, buffered immediate generator for the ID stage. Replaces the purely combinational extender.
- Accepts the 25-bit instruction immediate field (instr[31:7]) and a 3-bit format select under a valid/ready handshake.
- Extends the field to XLEN bits and queues the result in a small FIFO, so the EX-side consumer can stall without back-pressuring decode combinationally.
- Adds CSR-zimm and shift-amount formats, correct U-type placement, illegal-format flagging and a pipeline flush.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- DEPTH, 2, FIFO entries; power of two, at least 2.

Ports:
- i_clk  input  1  clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_flush  input  1  synchronous flush; discards all queued entries.
- i_valid_ID  input  1  upstream has an immediate to extend.
- o_ready_ID  output  1  block can accept; equals not-full.
- i_imm_ID  input  25  instruction bits [31:7].
- i_imm_src_ID  input  3  format select.
- o_valid_EX  output  1  head entry is valid.
- i_ready_EX  input  1  downstream accepts the head entry.
- o_imm_ex_EX  output  XLEN  extended immediate at the head.
- o_illegal_EX  output  1  head entry carried an illegal format select.
- o_count  output  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset is asynchronous and active-low, one clock. Reset values: o_valid_EX=0, o_ready_ID=1, o_imm_ex_EX=0, o_illegal_EX=0, o_count=0. Pointers are cleared.
- Push occurs when i_valid_ID and o_ready_ID are both high. Pop occurs when o_valid_EX and i_ready_EX are both high.
- Latency: a pushed entry is visible at the head on the next cycle. With an empty FIFO, o_valid_EX rises the cycle after the push.
- Extension happens before storage. Entries hold XLEN+1 bits: the immediate plus the illegal flag. Let s = i_imm_ID[24] and f = i_imm_ID.
  - 000 I: sign-extend f[24:13].
  - 001 S: sign-extend {f[24:18],f[4:0]}.
  - 010 B: sign-extend {f[24],f[0],f[23:18],f[4:1],1'b0}.
  - 011 J: sign-extend {f[24],f[12:5],f[13],f[23:14],1'b0}.
  - 100 U: sign-extend {f[24:5],12'b0}. Bits 31:12 come from the field and bits 11:0 are zero; when XLEN=64, bits 63:32 = s.
  - 101 Z (CSR zimm): zero-extend f[12:8].
  - 110 SH: zero-extend the shift amount. XLEN=32 uses f[17:13] (5 bits); XLEN=64 uses f[18:13] (6 bits).
  - 111: immediate=0 and illegal flag=1.
- Full: o_ready_ID=0 when o_count==DEPTH. While full, a same-cycle pop does not enable a push; ready is registered and has no pass-through path.
- Empty: o_valid_EX=0 and o_imm_ex_EX holds its last value. Consumers must qualify it with o_valid_EX.
- Simultaneous push and pop when not full or empty: o_count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH.
- Flush: the next cycle shows o_count=0 and o_valid_EX=0. Flush takes priority over a push or pop in the same cycle; the pushed entry is dropped. o_ready_ID is high again in the cycle after a flush.
- Reset mid-operation discards all entries immediately.

Optional Feature:
- Macro IMM_GEN_BUF_BYPASS_EN.
- Defined: when the FIFO is empty and i_valid_ID is high, the freshly extended value and flag drive the head outputs combinationally, with o_valid_EX=i_valid_ID.
  - If i_ready_EX is also high, the entry is consumed with zero latency and not written.
  - Otherwise it is written normally.
  - During flush the bypass is suppressed.
- Undefined: latency is always one cycle, as described in Behaviour.

Test Plan:
- I-type negative: push f=25'h1FFE000, src=000, XLEN=32, i_ready_EX=1 -> next cycle o_valid_EX=1, o_imm_ex_EX=32'hFFFFFFFF; B-type f=25'h1000001, src=010 -> 32'hFFFFF800.
- U and Z: f=25'h0ABCD<<5 (=25'h157_9A0), src=100 -> 32'h0ABCD000; f=25'h1F00 (bits 12:8 = 5'h1F), src=101 -> 32'h0000001F; with XLEN=64, U f[24]=1 -> upper 32 bits all ones.
- Back-pressure: i_ready_EX=0, push 3 entries with DEPTH=2 -> o_ready_ID=0 after 2 pushes, o_count=2, third is not accepted; release i_ready_EX -> entries pop in push order.
- Simultaneous push/pop at count=1 -> o_count stays 1 and the output order is preserved.
- Illegal format: src=111 -> o_imm_ex_EX=0, o_illegal_EX=1 for that entry only.
- Flush with count=2 plus a concurrent push -> next cycle o_count=0, o_valid_EX=0; assert i_rst_n=0 mid-stream -> outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/imm_gen_buf_if.sv
// -----------------------------------------------------------------------------
// imm_gen_buf_if
// Handshake bundle between decode (push side), the buffered immediate
// generator and the EX-side consumer (pop side).
//
//   i_flush        : synchronous flush request into the buffer
//   i_valid_ID     : decode offers an immediate field
//   o_ready_ID     : buffer can accept (registered not-full)
//   i_imm_ID       : instruction bits [31:7]
//   i_imm_src_ID   : format select
//   o_valid_EX     : head entry valid
//   i_ready_EX     : consumer accepts the head entry
//   o_imm_ex_EX    : extended immediate at the head
//   o_illegal_EX   : head entry carried an illegal format select
//   o_count        : occupied entries
//
// Modports: slave = buffer view, master = upstream/downstream environment.
// -----------------------------------------------------------------------------
interface imm_gen_buf_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) ();
  logic                     i_flush;
  logic                     i_valid_ID;
  logic                     o_ready_ID;
  logic [24:0]              i_imm_ID;
  logic [2:0]               i_imm_src_ID;
  logic                     o_valid_EX;
  logic                     i_ready_EX;
  logic [XLEN-1:0]          o_imm_ex_EX;
  logic                     o_illegal_EX;
  logic [$clog2(DEPTH):0]   o_count;

  modport slave (
    input  i_flush,
    input  i_valid_ID,
    output o_ready_ID,
    input  i_imm_ID,
    input  i_imm_src_ID,
    output o_valid_EX,
    input  i_ready_EX,
    output o_imm_ex_EX,
    output o_illegal_EX,
    output o_count
  );

  modport master (
    output i_flush,
    output i_valid_ID,
    input  o_ready_ID,
    output i_imm_ID,
    output i_imm_src_ID,
    input  o_valid_EX,
    output i_ready_EX,
    input  o_imm_ex_EX,
    input  o_illegal_EX,
    input  o_count
  );
endinterface

// File: rtl/imm_gen_buf.sv
// -----------------------------------------------------------------------------
// imm_gen_buf
// Buffered immediate generator for the ID stage. The 25-bit immediate field is
// extended to XLEN bits (plus an illegal-format flag) before it is stored in a
// small FIFO, so the EX-side consumer can stall without a combinational
// back-pressure path into decode.
//
// Ports:
//   i_clk    : clock, rising edge
//   i_rst_n  : asynchronous active-low reset
//   bus      : imm_gen_buf_if.slave (push/pop handshake, flush, count)
//
// Parameters: XLEN (32 or 64), DEPTH (power of two, >= 2).
//
// Optional feature macro: IMM_GEN_BUF_BYPASS_EN
//   When defined, an empty buffer forwards the freshly extended value straight
//   to the head outputs; if the consumer takes it in that cycle it is never
//   written. When undefined, head latency is always one cycle.
// -----------------------------------------------------------------------------
module imm_gen_buf #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  imm_gen_buf_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = XLEN + 1;

  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  // Entry layout: {illegal, immediate[XLEN-1:0]}.
  function automatic logic [EW-1:0] extend_imm(input logic [24:0] f,
                                               input logic [2:0]  src);
    logic [XLEN-1:0] imm;
    logic            ill;
    imm = '0;
    ill = 1'b0;
    case (src)
      3'b000: imm = XLEN'($signed(f[24:13]));
      3'b001: imm = XLEN'($signed({f[24:18], f[4:0]}));
      3'b010: imm = XLEN'($signed({f[24], f[0], f[23:18], f[4:1], 1'b0}));
      3'b011: imm = XLEN'($signed({f[24], f[12:5], f[13], f[23:14], 1'b0}));
      // U-type: field lands in bits 31:12, sign only matters for XLEN=64.
      3'b100: imm = XLEN'($signed({f[24:5], 12'h000}));
      3'b101: imm = XLEN'(f[12:8]);
      // Shift amount is 6 bits wide only on a 64-bit datapath.
      3'b110: begin
        if (XLEN == 64) begin
          imm = XLEN'(f[18:13]);
        end else begin
          imm = XLEN'(f[17:13]);
        end
      end
      3'b111: begin
        imm = '0;
        ill = 1'b1;
      end
      default: begin
        imm = '0;
        ill = 1'b1;
      end
    endcase
    return {ill, imm};
  endfunction

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic          ready_q, ready_d;
  logic [EW-1:0] head_q, head_d;

  logic [EW-1:0] ext_s;
  logic          push_s;
  logic          pop_s;
  logic          wr_s;
  logic          mem_we_s;
  logic          byp_s;
  logic          byp_take_s;

  // Extension of the incoming field and handshake qualification.
  always_comb begin
    ext_s  = extend_imm(bus.i_imm_ID, bus.i_imm_src_ID);
    // ready_q is registered, so a pop while full cannot open the push path.
    push_s = bus.i_valid_ID & ready_q;
    pop_s  = valid_q & bus.i_ready_EX;
`ifdef IMM_GEN_BUF_BYPASS_EN
    byp_s      = (count_q == CNT_ZERO) & bus.i_valid_ID & ~bus.i_flush;
    byp_take_s = byp_s & bus.i_ready_EX;
`else
    byp_s      = 1'b0;
    byp_take_s = 1'b0;
`endif
    // An entry consumed through the bypass is never stored.
    wr_s     = push_s & ~byp_take_s;
    mem_we_s = wr_s & ~bus.i_flush;
  end

  // Next-state for pointers, occupancy and the registered head view.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (bus.i_flush) begin
      // Flush wins over any same-cycle push or pop; head data is left as-is.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = CNT_ZERO;
      head_d   = head_q;
    end else begin
      if (wr_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // The new head is the entry written this cycle only when nothing older
      // remains; otherwise it is already in storage. Empty keeps the old value.
      if (count_d != CNT_ZERO) begin
        if (wr_s && (rd_ptr_d == wr_ptr_q)) begin
          head_d = ext_s;
        end else begin
          head_d = mem_q[rd_ptr_d];
        end
      end else begin
        head_d = head_q;
      end
    end
    valid_d = (count_d != CNT_ZERO);
    ready_d = (count_d != CNT_FULL);
  end

  // State registers and FIFO storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= CNT_ZERO;
      valid_q  <= 1'b0;
      ready_q  <= 1'b1;
      head_q   <= '0;
    end else begin
      if (mem_we_s) begin
        mem_q[wr_ptr_q] <= ext_s;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      ready_q  <= ready_d;
      head_q   <= head_d;
    end
  end

  // Output drive; the bypass mux collapses to the registers when disabled.
  assign bus.o_ready_ID   = ready_q;
  assign bus.o_count      = count_q;
  assign bus.o_valid_EX   = byp_s | valid_q;
  assign bus.o_imm_ex_EX  = byp_s ? ext_s[XLEN-1:0] : head_q[XLEN-1:0];
  assign bus.o_illegal_EX = byp_s ? ext_s[XLEN]     : head_q[XLEN];

  imm_gen_buf_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_count (count_q),
    .i_valid (valid_q),
    .i_ready (ready_q)
  );

endmodule

// -----------------------------------------------------------------------------
// imm_gen_buf_chk
// Occupancy invariants of the buffer: count bounded by DEPTH, registered
// valid/ready consistent with the count.
// Ports: i_clk, i_rst_n, i_count, i_valid, i_ready (all inputs).
// -----------------------------------------------------------------------------
module imm_gen_buf_chk #(
  parameter int DEPTH = 2
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  input logic [$clog2(DEPTH):0] i_count,
  input logic                   i_valid,
  input logic                   i_ready
);
  localparam logic [$clog2(DEPTH):0] CNT_FULL = ($clog2(DEPTH)+1)'(DEPTH);

  a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_count <= CNT_FULL)
    else $error("imm_gen_buf: count above depth");

  a_valid_count: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_valid == (i_count != '0))
    else $error("imm_gen_buf: valid inconsistent with count");

  a_ready_count: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    i_ready == (i_count != CNT_FULL))
    else $error("imm_gen_buf: ready inconsistent with count");
endmodule

// File: tb/tb_imm_gen_buf.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_buf
// Directed bench for imm_gen_buf: a 32-bit/DEPTH=2 instance for the main
// behaviour and a 64-bit instance for the width-dependent formats.
// -----------------------------------------------------------------------------
module tb_imm_gen_buf;

  logic clk;
  logic rst_n;

  int total;
  int bad;

  imm_gen_buf_if #(.XLEN(32), .DEPTH(2)) bus32 ();
  imm_gen_buf_if #(.XLEN(64), .DEPTH(2)) bus64 ();

  imm_gen_buf #(.XLEN(32), .DEPTH(2)) dut32 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus32)
  );

  imm_gen_buf #(.XLEN(64), .DEPTH(2)) dut64 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one vector into an empty, free-flowing buffer and check the head.
  task automatic push_chk(input bit wide, input logic [24:0] f, input logic [2:0] src,
                          input logic [63:0] exp_imm, input logic exp_ill, input string tag);
    if (wide) begin
      bus64.i_imm_ID = f; bus64.i_imm_src_ID = src; bus64.i_valid_ID = 1'b1;
    end else begin
      bus32.i_imm_ID = f; bus32.i_imm_src_ID = src; bus32.i_valid_ID = 1'b1;
    end
    tick();
    bus32.i_valid_ID = 1'b0;
    bus64.i_valid_ID = 1'b0;
    if (wide) begin
      chk({tag, "_valid"}, 64'(bus64.o_valid_EX), 64'd1);
      chk({tag, "_imm"}, bus64.o_imm_ex_EX, exp_imm);
      chk({tag, "_ill"}, 64'(bus64.o_illegal_EX), 64'(exp_ill));
    end else begin
      chk({tag, "_valid"}, 64'(bus32.o_valid_EX), 64'd1);
      chk({tag, "_imm"}, 64'(bus32.o_imm_ex_EX), exp_imm);
      chk({tag, "_ill"}, 64'(bus32.o_illegal_EX), 64'(exp_ill));
    end
    tick();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus32.i_flush = 1'b0; bus32.i_valid_ID = 1'b0; bus32.i_imm_ID = 25'h0;
    bus32.i_imm_src_ID = 3'b000; bus32.i_ready_EX = 1'b1;
    bus64.i_flush = 1'b0; bus64.i_valid_ID = 1'b0; bus64.i_imm_ID = 25'h0;
    bus64.i_imm_src_ID = 3'b000; bus64.i_ready_EX = 1'b1;

    #12;
    chk("rst_valid", 64'(bus32.o_valid_EX), 64'd0);
    chk("rst_ready", 64'(bus32.o_ready_ID), 64'd1);
    chk("rst_imm", 64'(bus32.o_imm_ex_EX), 64'd0);
    chk("rst_ill", 64'(bus32.o_illegal_EX), 64'd0);
    chk("rst_count", 64'(bus32.o_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // Format coverage, one entry at a time.
    push_chk(1'b0, 25'h1FFE000, 3'b000, 64'h0000_0000_FFFF_FFFF, 1'b0, "i_neg");
    chk("pop_empty_valid", 64'(bus32.o_valid_EX), 64'd0);
    chk("pop_empty_hold", 64'(bus32.o_imm_ex_EX), 64'h0000_0000_FFFF_FFFF);
    push_chk(1'b0, 25'h0040005, 3'b001, 64'h0000_0000_0000_0025, 1'b0, "s_pos");
    push_chk(1'b0, 25'h1000001, 3'b010, 64'h0000_0000_FFFF_F800, 1'b0, "b_neg");
    push_chk(1'b0, 25'h1000000, 3'b011, 64'h0000_0000_FFF0_0000, 1'b0, "j_neg");
    push_chk(1'b0, 25'h01579A0, 3'b100, 64'h0000_0000_0ABC_D000, 1'b0, "u32");
    push_chk(1'b0, 25'h0001F00, 3'b101, 64'h0000_0000_0000_001F, 1'b0, "zimm");
    push_chk(1'b0, 25'h007E000, 3'b110, 64'h0000_0000_0000_001F, 1'b0, "sh32");
    push_chk(1'b0, 25'h1FFFFFF, 3'b111, 64'h0000_0000_0000_0000, 1'b1, "illegal");
    push_chk(1'b0, 25'h0002000, 3'b000, 64'h0000_0000_0000_0001, 1'b0, "after_ill");
    push_chk(1'b1, 25'h1800000, 3'b100, 64'hFFFF_FFFF_C000_0000, 1'b0, "u64");
    push_chk(1'b1, 25'h007E000, 3'b110, 64'h0000_0000_0000_003F, 1'b0, "sh64");

    // Back-pressure: fill to DEPTH, hold a third push while full.
    bus32.i_ready_EX = 1'b0;
    bus32.i_imm_src_ID = 3'b000;
    bus32.i_valid_ID = 1'b1; bus32.i_imm_ID = 25'h0002000;
    tick();
    chk("bp_cnt1", 64'(bus32.o_count), 64'd1);
    bus32.i_imm_ID = 25'h0004000;
    tick();
    chk("bp_ready_full", 64'(bus32.o_ready_ID), 64'd0);
    chk("bp_cnt2", 64'(bus32.o_count), 64'd2);
    bus32.i_imm_ID = 25'h0006000;
    tick();
    chk("bp_third_dropped", 64'(bus32.o_count), 64'd2);
    chk("bp_head_a", 64'(bus32.o_imm_ex_EX), 64'd1);
    // Pop while full: the pending push must not slip in this cycle.
    bus32.i_ready_EX = 1'b1;
    tick();
    chk("full_pop_cnt", 64'(bus32.o_count), 64'd1);
    chk("full_pop_head_b", 64'(bus32.o_imm_ex_EX), 64'd2);
    // Now at count=1: push and pop together.
    tick();
    chk("pp_cnt", 64'(bus32.o_count), 64'd1);
    chk("pp_head_c", 64'(bus32.o_imm_ex_EX), 64'd3);
    bus32.i_valid_ID = 1'b0;
    tick();
    chk("drain_cnt", 64'(bus32.o_count), 64'd0);
    chk("drain_valid", 64'(bus32.o_valid_EX), 64'd0);

    // Flush at count=2 with a concurrent push.
    bus32.i_ready_EX = 1'b0;
    bus32.i_valid_ID = 1'b1; bus32.i_imm_ID = 25'h0002000;
    tick();
    bus32.i_imm_ID = 25'h0004000;
    tick();
    chk("fl_pre_cnt", 64'(bus32.o_count), 64'd2);
    bus32.i_flush = 1'b1; bus32.i_imm_ID = 25'h0006000;
    tick();
    bus32.i_flush = 1'b0; bus32.i_valid_ID = 1'b0;
    chk("fl_cnt", 64'(bus32.o_count), 64'd0);
    chk("fl_valid", 64'(bus32.o_valid_EX), 64'd0);
    chk("fl_ready", 64'(bus32.o_ready_ID), 64'd1);

    // Asynchronous reset mid-stream.
    bus32.i_valid_ID = 1'b1; bus32.i_imm_ID = 25'h1FFE000;
    tick();
    bus32.i_valid_ID = 1'b0;
    chk("ar_pre_cnt", 64'(bus32.o_count), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(bus32.o_valid_EX), 64'd0);
    chk("ar_ready", 64'(bus32.o_ready_ID), 64'd1);
    chk("ar_imm", 64'(bus32.o_imm_ex_EX), 64'd0);
    chk("ar_ill", 64'(bus32.o_illegal_EX), 64'd0);
    chk("ar_count", 64'(bus32.o_count), 64'd0);
    #3;
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
